// File: rtl/regs_pkg.sv
// regs_pkg: shared constants and helpers for the rua integer register file.
//   XLEN      data width of one architectural register
//   NREGS     architectural register count (x0..x31)
//   REG_AW    register address width
//   CNT_W     width of the busy-register count (must hold 0..NREGS-1)
//   X0_ADDR   address of the hard-wired zero register
//   popcount  number of set bits in a busy vector
package regs_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 6;

  localparam logic [REG_AW-1:0] X0_ADDR = '0;

  function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regs_scoreboard.sv
// regs_scoreboard: per-register busy tracking and the issue decision.
//   clk, rst         clock and synchronous active-high reset
//   rs1, rs2         source addresses of the decoded instruction
//   rd, rd_en        destination address and its write enable
//   issue_valid      decode presents an instruction this cycle
//   wb_en, wb_addr   write-back port (clears the destination's busy bit)
//   issue_ready      combinational: instruction may issue this cycle
//   busy_count       registered popcount of the busy vector
module regs_scoreboard
  import regs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              rd_en,
  input  logic              issue_valid,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  output logic              issue_ready,
  output logic [CNT_W-1:0]  busy_count
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] busy_count_q, busy_count_d;
  logic             src1_ok, src2_ok, dst_ok, fire;

  // A source waiting on a write-back becomes ready in the write-back cycle
  // itself, because the read mux bypasses wb_data.
  always_comb begin
    src1_ok = !busy_q[rs1] || (wb_en && (wb_addr == rs1));
    src2_ok = !busy_q[rs2] || (wb_en && (wb_addr == rs2));
    // The destination check deliberately ignores a same-cycle write-back, so
    // a WAW stall lasts one cycle past the producer's write-back.
    dst_ok  = !rd_en || (rd == X0_ADDR) || !busy_q[rd];
    issue_ready = src1_ok && src2_ok && dst_ok;
    fire        = issue_valid && issue_ready;
  end

  // Clear first, then set, so a set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en && (wb_addr != X0_ADDR)) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (fire && rd_en && (rd != X0_ADDR)) begin
      busy_d[rd] = 1'b1;
    end
    busy_d[0]    = 1'b0;
    busy_count_d = popcount(busy_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

endmodule

// File: rtl/regs.sv
// regs: RV32I integer register file with write-back bypass and issue scoreboard.
//   clk, rst                 clock and synchronous active-high reset
//   regs_addr1, regs_addr2   source addresses from decode
//   regs_write_en/_addr      decoded destination
//   issue_valid              decode presents an instruction
//   issue_ready              instruction may issue (combinational)
//   regs_data1, regs_data2   source values (combinational, bypassed)
//   wb_en, wb_addr, wb_data  write-back port
//   busy_count               number of busy registers (registered)
module regs
  import regs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] regs_addr1,
  input  logic [REG_AW-1:0] regs_addr2,
  input  logic              regs_write_en,
  input  logic [REG_AW-1:0] regs_write_addr,
  input  logic              issue_valid,
  output logic              issue_ready,
  output logic [XLEN-1:0]   regs_data1,
  output logic [XLEN-1:0]   regs_data2,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [CNT_W-1:0]  busy_count
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic            wb_live;

  assign wb_live = wb_en && (wb_addr != X0_ADDR);

  always_comb begin
    mem_d = mem_q;
    if (wb_live) begin
      mem_d[wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // x0 reads as zero regardless of storage; a live write-back overrides storage.
  always_comb begin
    regs_data1 = '0;
    if (regs_addr1 != X0_ADDR) begin
      regs_data1 = mem_q[regs_addr1];
    end
    if (wb_live && (wb_addr == regs_addr1)) begin
      regs_data1 = wb_data;
    end
    regs_data2 = '0;
    if (regs_addr2 != X0_ADDR) begin
      regs_data2 = mem_q[regs_addr2];
    end
    if (wb_live && (wb_addr == regs_addr2)) begin
      regs_data2 = wb_data;
    end
  end

  regs_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rs1         (regs_addr1),
    .rs2         (regs_addr2),
    .rd          (regs_write_addr),
    .rd_en       (regs_write_en),
    .issue_valid (issue_valid),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .issue_ready (issue_ready),
    .busy_count  (busy_count)
  );

endmodule

// File: tb/tb_regs.sv
// tb_regs: bench for the regs register file. A behavioural model (value and
// busy arrays) is compared against the DUT on every falling edge, after a
// directed sequence with literal expectations and a randomized phase.
module tb_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  regs_addr1 = '0, regs_addr2 = '0;
  logic        regs_write_en = 1'b0;
  logic [4:0]  regs_write_addr = '0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [31:0] regs_data1, regs_data2;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [5:0]  busy_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  bit [31:0] m_val [32];
  bit        m_busy [32];

  regs dut (
    .clk             (clk),
    .rst             (rst),
    .regs_addr1      (regs_addr1),
    .regs_addr2      (regs_addr2),
    .regs_write_en   (regs_write_en),
    .regs_write_addr (regs_write_addr),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .regs_data1      (regs_data1),
    .regs_data2      (regs_data2),
    .wb_en           (wb_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .busy_count      (busy_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---- reference model ----
  function automatic bit [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_val[a];
  endfunction

  function automatic bit m_ready();
    bit s1, s2, d;
    s1 = (regs_addr1 == 0) || !m_busy[regs_addr1] || (wb_en && wb_addr == regs_addr1);
    s2 = (regs_addr2 == 0) || !m_busy[regs_addr2] || (wb_en && wb_addr == regs_addr2);
    d  = !regs_write_en || (regs_write_addr == 0) || !m_busy[regs_write_addr];
    return s1 && s2 && d;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  always @(posedge clk) begin
    bit fire;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      fire = issue_valid && m_ready();
      if (wb_en && wb_addr != 0) begin
        m_val[wb_addr]  = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (fire && regs_write_en && regs_write_addr != 0) m_busy[regs_write_addr] = 1'b1;
    end
  end

  // ---- compare process ----
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_data1", regs_data1, m_read(regs_addr1));
      chk("model_data2", regs_data2, m_read(regs_addr2));
      chk("model_ready", {31'b0, issue_ready}, {31'b0, m_ready()});
      chk("model_count", {26'b0, busy_count}, 32'(m_count()));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; regs_write_en = 0; regs_write_addr = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; regs_addr1 = 0; regs_addr2 = 0;
  endtask

  initial begin
    // Reset then read
    nxt();
    rst = 0; check_en = 1;
    regs_addr1 = 5; regs_addr2 = 31;
    @(negedge clk);
    chk("rst_data1", regs_data1, 32'h0);
    chk("rst_data2", regs_data2, 32'h0);
    chk("rst_ready", {31'b0, issue_ready}, 32'h1);
    chk("rst_count", {26'b0, busy_count}, 32'h0);

    // Write then read
    nxt();
    wb_en = 1; wb_addr = 3; wb_data = 32'hDEADBEEF; regs_addr1 = 3;
    @(negedge clk);
    chk("wb_bypass", regs_data1, 32'hDEADBEEF);
    nxt();
    wb_en = 0;
    @(negedge clk);
    chk("wb_stored", regs_data1, 32'hDEADBEEF);

    // x0 handling
    nxt();
    wb_en = 1; wb_addr = 0; wb_data = 32'h1234; regs_addr1 = 0;
    @(negedge clk);
    chk("x0_read", regs_data1, 32'h0);
    nxt();
    wb_en = 0; issue_valid = 1; regs_write_en = 1; regs_write_addr = 0;
    @(negedge clk);
    chk("x0_issue_ready", {31'b0, issue_ready}, 32'h1);
    nxt();
    idle();
    @(negedge clk);
    chk("x0_count", {26'b0, busy_count}, 32'h0);

    // RAW stall
    nxt();
    issue_valid = 1; regs_write_en = 1; regs_write_addr = 7;
    @(negedge clk);
    chk("raw_prod_ready", {31'b0, issue_ready}, 32'h1);
    nxt();
    regs_write_en = 0; regs_write_addr = 0; regs_addr1 = 7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("raw_stall", {31'b0, issue_ready}, 32'h0);
      chk("raw_count", {26'b0, busy_count}, 32'h1);
      nxt();
    end
    wb_en = 1; wb_addr = 7; wb_data = 32'h55;
    @(negedge clk);
    chk("raw_release", {31'b0, issue_ready}, 32'h1);
    chk("raw_data", regs_data1, 32'h55);
    nxt();
    idle();
    @(negedge clk);
    chk("raw_count_clr", {26'b0, busy_count}, 32'h0);

    // WAW stall
    nxt();
    issue_valid = 1; regs_write_en = 1; regs_write_addr = 9;
    nxt();
    @(negedge clk);
    chk("waw_stall", {31'b0, issue_ready}, 32'h0);
    chk("waw_count", {26'b0, busy_count}, 32'h1);
    nxt();
    wb_en = 1; wb_addr = 9; wb_data = 32'h9;
    @(negedge clk);
    chk("waw_wb_cycle", {31'b0, issue_ready}, 32'h0);
    nxt();
    wb_en = 0;
    @(negedge clk);
    chk("waw_release", {31'b0, issue_ready}, 32'h1);
    nxt();
    idle();
    wb_en = 1; wb_addr = 9; wb_data = 32'h99;
    nxt();
    idle();

    // Reset mid-flight
    issue_valid = 1; regs_write_en = 1; regs_write_addr = 4;
    nxt();
    regs_write_addr = 6;
    nxt();
    idle();
    @(negedge clk);
    chk("mid_count_before", {26'b0, busy_count}, 32'h2);
    nxt();
    rst = 1; wb_en = 1; wb_addr = 4; wb_data = 32'h99;
    nxt();
    rst = 0; idle(); regs_addr1 = 4; regs_addr2 = 6;
    @(negedge clk);
    chk("mid_count", {26'b0, busy_count}, 32'h0);
    chk("mid_x4", regs_data1, 32'h0);
    chk("mid_ready", {31'b0, issue_ready}, 32'h1);

    // Randomized phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nxt();
      rst             = ($urandom_range(0, 299) == 0);
      regs_addr1      = 5'($urandom_range(0, 31));
      regs_addr2      = 5'($urandom_range(0, 31));
      issue_valid     = ($urandom_range(0, 3) != 0);
      regs_write_en   = ($urandom_range(0, 3) != 0);
      regs_write_addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) regs_write_addr = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) regs_addr1 = regs_write_addr;
      wb_en   = ($urandom_range(0, 2) == 0);
      wb_data = $urandom;
      wb_addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) < 7) begin
        for (int k = 0; k < 8; k++) begin
          logic [4:0] a;
          a = 5'($urandom_range(1, 31));
          if (m_busy[a]) begin
            wb_addr = a;
            break;
          end
        end
      end
    end
    nxt();
    rst = 0;
    idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
